toggle_driver: RTL and testbench
================================

// Module: toggle_driver
// PURPOSE
//  Synthesisable driver end of the edge-toggle protocol. On a handshaked
//  request it toggles sig_o a given number of times, with a programmable
//  half-period between toggles, and counts the rising edges it emits.
//  It sits in front of any consumer that waits on N posedges of sig_o.
//  done_o reports completion back to the requester.
// PARAMETERS
//  CNT_W       8   width of toggle count and posedge counter
//  PER_W       8   width of half-period (clock cycles between toggles)
//  INIT_LEVEL  1'b0 level of sig_o after reset
// PORTS
//  clk               input   1      sole clock, rising edge
//  rst_n             input   1      asynchronous, active-low reset
//  req_valid_i       input   1      request valid
//  req_ready_o       output  1      request ready (high only in IDLE)
//  req_toggles_i     input   CNT_W  number of toggles to emit
//  req_half_period_i input   PER_W  cycles between toggles; 0 is treated as 1
//  abort_i           input   1      cancel the request in flight
//  sig_o             output  1      toggled output signal (registered)
//  busy_o            output  1      high while in RUN
//  done_o            output  1      one-cycle completion pulse
//  posedges_o        output  CNT_W  rising edges of sig_o in current request
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, sig_o=INIT_LEVEL, busy_o=0,
//    done_o=0, posedges_o=0, internal counters=0; req_ready_o=1 once in IDLE.
//  - Accept on a rising clk edge with req_valid_i && req_ready_o. Latch
//    toggles and half-period (0 becomes 1), clear posedges_o, load the
//    period counter with P.
//  - Accept with toggles==0: stay in IDLE; done_o=1 on the next edge;
//    sig_o is unchanged.
//  - Accept with toggles!=0: go to RUN (busy_o=1, req_ready_o=0).
//  - RUN: the period counter decrements every cycle. On the edge where it
//    would reach 0:
//      sig_o <= ~sig_o; remaining--; counter reloads with P.
//    The k-th toggle happens exactly k*P edges after the accept edge.
//  - Rising transition of sig_o (0->1): posedges_o++, wrapping modulo 2^CNT_W.
//  - Last toggle (remaining reaches 0): on that same edge go to IDLE and
//    set done_o=1 for exactly one cycle. req_ready_o is high in the next cycle.
//  - Back-to-back: a request may be accepted the cycle after done_o.
//    sig_o keeps its level between requests and is never re-initialised
//    except by reset.
//  - abort_i in RUN: IDLE on the next edge. sig_o and posedges_o hold their
//    values, no done_o, the remaining count is discarded. abort_i has
//    priority over a toggle due on the same edge. abort_i is ignored in IDLE.
//  - req_valid_i while busy is ignored: no accept and no side effects.
//  - Reset mid-RUN: immediate return to the reset values above.
//  - Widths: all counters unsigned. Half-period 2^PER_W-1 is legal.
// STRUCTURE
//  - toggle_pkg: typedef enum logic {IDLE, RUN} toggle_state_e;
//    localparam defaults for CNT_W/PER_W.
//  - One sub-module, toggle_period_timer: load/decrement counter that pulses
//    'tick' every P cycles while enabled.
//  - The top-level FSM, sig_o register and posedge counter live in
//    toggle_driver.
// TESTING
//  - sig_o=0, req toggles=3, P=5, accept at edge t0 -> sig_o 1@t0+5, 0@t0+10,
//    1@t0+15; done_o=1 only at t0+15; posedges_o=2; busy_o=0 after.
//  - toggles=0, P=4 -> no toggle, done_o=1 one cycle after accept,
//    req_ready_o stays 1.
//  - P=0, toggles=4 -> toggle every cycle (treated as P=1), done_o at 4th
//    edge, posedges_o=2.
//  - toggles=6, P=3, abort_i at t0+7 -> exactly 2 toggles, no done_o,
//    posedges_o=1, IDLE at t0+8.
//  - req_valid_i held high during RUN -> one accept only; a second request
//    issued the cycle after done_o is accepted and starts from the current
//    sig_o level.
//  - rst_n low mid-RUN at t0+6 (toggles=4, P=2) -> sig_o=INIT_LEVEL,
//    busy_o=0, posedges_o=0 immediately; no done_o.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared types and default widths for the edge-toggle driver.
package toggle_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } toggle_state_e;

    localparam int CNT_W_DEF = 8;
    localparam int PER_W_DEF = 8;

endpackage

// File: rtl/toggle_period_timer.sv
// Reloading down-counter that pulses tick every P enabled cycles.
module toggle_period_timer #(
    parameter int PER_W = toggle_pkg::PER_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    logic [PER_W-1:0] cnt_q;
    logic [PER_W-1:0] period_q;

    // tick marks the edge on which the count would reach zero; the reload
    // happens on that same edge so the spacing stays exactly P.
    assign tick = en && (cnt_q == PER_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else if (load) begin
            cnt_q    <= load_val;
            period_q <= load_val;
        end else if (en) begin
            if (tick) cnt_q <= period_q;
            else      cnt_q <= cnt_q - PER_W'(1);
        end
    end

endmodule

// File: rtl/toggle_driver.sv
// Driver end of the edge-toggle protocol: emits N toggles of sig_o spaced
// P cycles apart per handshaked request and counts the rising edges.
//
// state | meaning
// IDLE  | waiting for a request, req_ready_o high
// RUN   | emitting toggles, busy_o high
module toggle_driver
    import toggle_pkg::*;
#(
    parameter int   CNT_W      = CNT_W_DEF,
    parameter int   PER_W      = PER_W_DEF,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [CNT_W-1:0] req_toggles_i,
    input  logic [PER_W-1:0] req_half_period_i,
    input  logic             abort_i,
    output logic             sig_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] posedges_o
);

    toggle_state_e    state_q;
    logic             sig_q;
    logic             done_q;
    logic [CNT_W-1:0] posedges_q;
    logic [CNT_W-1:0] remaining_q;
    logic             accept;
    logic             tick;
    logic [PER_W-1:0] period_norm;

    assign accept      = (state_q == IDLE) && req_valid_i;
    assign period_norm = (req_half_period_i == '0) ? PER_W'(1) : req_half_period_i;

    // Abort masks the timer so a toggle due on the abort edge is dropped.
    toggle_period_timer #(.PER_W(PER_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (period_norm),
        .en       ((state_q == RUN) && !abort_i),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sig_q       <= INIT_LEVEL;
            done_q      <= 1'b0;
            posedges_q  <= '0;
            remaining_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        posedges_q  <= '0;
                        remaining_q <= req_toggles_i;
                        if (req_toggles_i == '0) done_q  <= 1'b1;
                        else                     state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        sig_q       <= ~sig_q;
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (!sig_q) posedges_q <= posedges_q + CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == RUN);
    assign sig_o       = sig_q;
    assign done_o      = done_q;
    assign posedges_o  = posedges_q;

endmodule

// File: tb/tb_toggle_driver.sv
// Scoreboard bench for toggle_driver: expected toggle/done events are queued
// at request time and matched by a monitor as the DUT produces them.
module tb_toggle_driver;

    localparam int CNT_W = 8;
    localparam int PER_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [CNT_W-1:0] req_toggles_i;
    logic [PER_W-1:0] req_half_period_i;
    logic             abort_i;
    logic             sig_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] posedges_o;

    toggle_driver #(.CNT_W(CNT_W), .PER_W(PER_W), .INIT_LEVEL(1'b0)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_toggles_i     (req_toggles_i),
        .req_half_period_i (req_half_period_i),
        .abort_i           (abort_i),
        .sig_o             (sig_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .posedges_o        (posedges_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic lvl;
    } tog_t;

    tog_t tog_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic exp_level;
    int   exp_pos;
    logic prev_sig;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every sig_o change and every done pulse must match the queue head.
    always @(negedge clk) begin
        tog_t e;
        int   d;
        if (!rst_n) begin
            prev_sig = sig_o;
        end else begin
            if (sig_o !== prev_sig) begin
                checks++;
                if (tog_q.size() == 0) begin
                    errors++;
                    $display("FAIL toggle_unexpected cyc=%0d level=%b", cyc, sig_o);
                end else begin
                    e = tog_q.pop_front();
                    if (e.cyc != cyc || e.lvl !== sig_o) begin
                        errors++;
                        $display("FAIL toggle got cyc=%0d lvl=%b exp cyc=%0d lvl=%b",
                                 cyc, sig_o, e.cyc, e.lvl);
                    end
                end
                prev_sig = sig_o;
            end
            if (done_o === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d", cyc);
                end else begin
                    d = done_q.pop_front();
                    if (d != cyc) begin
                        errors++;
                        $display("FAIL done_time got cyc=%0d exp cyc=%0d", cyc, d);
                    end
                end
            end
        end
    end

    // Queue expected events for a request accepted on the next rising edge;
    // only the first 'keep' toggles are expected, done only if all complete.
    task automatic push_req(input int n, input int per, input int keep);
        int p;
        int t0;
        p  = (per == 0) ? 1 : per;
        t0 = cyc + 1;
        exp_pos = 0;
        for (int k = 1; k <= keep; k++) begin
            exp_level = ~exp_level;
            tog_q.push_back('{cyc: t0 + k * p, lvl: exp_level});
            if (exp_level) exp_pos++;
        end
        if (keep == n) done_q.push_back(n == 0 ? t0 : t0 + n * p);
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic drive_req(input int n, input int per, input int keep);
        req_valid_i       = 1'b1;
        req_toggles_i     = CNT_W'(n);
        req_half_period_i = PER_W'(per);
        push_req(n, per, keep);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid_i = 1'b0; abort_i = 1'b0;
        req_toggles_i = '0; req_half_period_i = '0;
        exp_level = 1'b0; exp_pos = 0;
        #12;
        checks += 5;
        if (sig_o !== 1'b0)      begin errors++; $display("FAIL reset_sig got %b exp 0", sig_o); end
        if (busy_o !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        if (done_o !== 1'b0)     begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
        if (posedges_o !== '0)   begin errors++; $display("FAIL reset_pos got %0d exp 0", posedges_o); end
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready_o); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        drive_req(3, 5, 3);
        checks += 2;
        if (busy_o !== 1'b1)      begin errors++; $display("FAIL basic_busy got %b exp 1", busy_o); end
        if (req_ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready got %b exp 0", req_ready_o); end
        repeat (17) @(negedge clk);
        checks += 3;
        if (posedges_o !== CNT_W'(exp_pos)) begin errors++; $display("FAIL basic_pos got %0d exp %0d", posedges_o, exp_pos); end
        if (busy_o !== 1'b0)      begin errors++; $display("FAIL basic_idle got %b exp 0", busy_o); end
        if (tog_q.size() + done_q.size() != 0) begin errors++; $display("FAIL basic_missing got %0d pending exp 0", tog_q.size() + done_q.size()); end
    endtask

    task automatic test_zero_toggles;
        drive_req(0, 4, 0);
        checks += 2;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", req_ready_o); end
        if (posedges_o !== '0)    begin errors++; $display("FAIL zero_pos got %0d exp 0", posedges_o); end
        repeat (6) @(negedge clk);
        checks += 3;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL zero_ready_after got %b exp 1", req_ready_o); end
        if (busy_o !== 1'b0)      begin errors++; $display("FAIL zero_busy got %b exp 0", busy_o); end
        if (done_q.size() != 0)   begin errors++; $display("FAIL zero_done_missing got %0d exp 0", done_q.size()); end
    endtask

    task automatic test_period(input int n, input int per, input string name);
        drive_req(n, per, n);
        repeat (n * ((per == 0) ? 1 : per) + 3) @(negedge clk);
        checks += 2;
        if (posedges_o !== CNT_W'(exp_pos)) begin errors++; $display("FAIL %s_pos got %0d exp %0d", name, posedges_o, exp_pos); end
        if (tog_q.size() + done_q.size() != 0) begin errors++; $display("FAIL %s_missing got %0d pending exp 0", name, tog_q.size() + done_q.size()); end
    endtask

    // Abort is driven during the cycle that ends with edge t0+abort_at.
    task automatic test_abort(input int n, input int per, input int keep, input int abort_at, input string name);
        drive_req(n, per, keep);
        repeat (abort_at - 1) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        checks += 3;
        if (busy_o !== 1'b0)      begin errors++; $display("FAIL %s_busy got %b exp 0", name, busy_o); end
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL %s_ready got %b exp 1", name, req_ready_o); end
        if (sig_o !== exp_level)  begin errors++; $display("FAIL %s_sig got %b exp %b", name, sig_o, exp_level); end
        repeat (2 * per + 2) @(negedge clk);
        checks += 2;
        if (posedges_o !== CNT_W'(exp_pos)) begin errors++; $display("FAIL %s_pos got %0d exp %0d", name, posedges_o, exp_pos); end
        if (tog_q.size() != 0)    begin errors++; $display("FAIL %s_missing got %0d exp 0", name, tog_q.size()); end
    endtask

    task automatic test_back_to_back;
        req_valid_i = 1'b1; req_toggles_i = 8'd2; req_half_period_i = 8'd2;
        push_req(2, 2, 2);
        @(negedge clk);
        req_toggles_i = 8'd7; req_half_period_i = 8'd1;
        repeat (3) @(negedge clk);
        checks += 2;
        if (busy_o !== 1'b1)   begin errors++; $display("FAIL b2b_busy got %b exp 1", busy_o); end
        if (posedges_o !== '0) begin errors++; $display("FAIL b2b_pos_mid got %0d exp 0", posedges_o); end
        @(negedge clk);
        req_valid_i = 1'b0;
        checks += 2;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", req_ready_o); end
        if (posedges_o !== CNT_W'(exp_pos)) begin errors++; $display("FAIL b2b_pos1 got %0d exp %0d", posedges_o, exp_pos); end
        @(negedge clk);
        drive_req(3, 1, 3);
        checks += 1;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_second_busy got %b exp 1", busy_o); end
        repeat (6) @(negedge clk);
        checks += 2;
        if (posedges_o !== CNT_W'(exp_pos)) begin errors++; $display("FAIL b2b_pos2 got %0d exp %0d", posedges_o, exp_pos); end
        if (tog_q.size() + done_q.size() != 0) begin errors++; $display("FAIL b2b_missing got %0d pending exp 0", tog_q.size() + done_q.size()); end
    endtask

    task automatic test_reset_mid_run;
        drive_req(4, 2, 4);
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        tog_q.delete();
        done_q.delete();
        exp_level = 1'b0;
        checks += 4;
        if (sig_o !== 1'b0)    begin errors++; $display("FAIL rst_mid_sig got %b exp 0", sig_o); end
        if (busy_o !== 1'b0)   begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy_o); end
        if (posedges_o !== '0) begin errors++; $display("FAIL rst_mid_pos got %0d exp 0", posedges_o); end
        if (done_o !== 1'b0)   begin errors++; $display("FAIL rst_mid_done got %b exp 0", done_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks += 1;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", req_ready_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_toggles();
        test_period(4, 0, "zero_period");
        test_period(1, 255, "max_period");
        test_abort(6, 3, 2, 8, "abort");
        test_abort(4, 2, 1, 4, "abort_prio");
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
